// File: rtl/serial_adder.sv
// Bit-serial adder: WIDTH-bit operands are summed LSB-first through one full-adder cell,
// with the parallel result and carry presented alongside a one-cycle done pulse.
module serial_adder #(
    parameter int unsigned WIDTH = 8  // legal range 2..32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic IDLE = 1'b0;
    localparam logic RUN  = 1'b1;

    logic             state;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] work;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             s;
    logic             carry_next;
    logic             last;
    logic [WIDTH-1:0] work_next;

    // Single full-adder cell shared across all bit positions.
    assign s          = ra[0] ^ rb[0] ^ carry;
    assign carry_next = (ra[0] & rb[0]) | (ra[0] & carry) | (rb[0] & carry);
    assign last       = (cnt == CW'(WIDTH - 1));
    assign work_next  = {s, work[WIDTH-1:1]};

    assign busy = (state == RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ra    <= '0;
            rb    <= '0;
            work  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            done  <= 1'b0;
            sum   <= '0;
            c_out <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        ra    <= a;
                        rb    <= b;
                        carry <= c_in;
                        cnt   <= '0;
                        work  <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    carry <= carry_next;
                    ra    <= {1'b0, ra[WIDTH-1:1]};
                    rb    <= {1'b0, rb[WIDTH-1:1]};
                    work  <= work_next;
                    cnt   <= cnt + CW'(1);
                    // Outputs are only touched here so partial sums never leak out.
                    if (last) begin
                        sum   <= work_next;
                        c_out <= carry_next;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases plus a randomized back-to-back run
// against an arithmetic reference model.
module tb_serial_adder;

    localparam int unsigned W = 8;
    localparam int unsigned PERIOD = W + 1;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         c_in = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         c_out;

    int checks = 0;
    int errors = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .c_out (c_out)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Issues one start, then watches until done. lat is cycles from start edge to done
    // (-1 on timeout); held reports that sum/c_out kept their old value until done.
    task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oc,
                         output int lat, output logic [W-1:0] rs, output logic rc,
                         output int busy_cycles, output bit held);
        logic [W-1:0] old_s;
        logic         old_c;
        old_s = sum;
        old_c = c_out;
        start = 1'b1; a = oa; b = ob; c_in = oc;
        cycle();
        start = 1'b0; a = W'($urandom); b = W'($urandom); c_in = 1'($urandom);
        lat = -1; busy_cycles = 0; held = 1'b1; rs = '0; rc = 1'b0;
        for (int i = 0; i <= int'(W) + 5; i++) begin
            if (done) begin
                lat = i; rs = sum; rc = c_out;
                break;
            end
            if (busy) busy_cycles++;
            if (sum !== old_s || c_out !== old_c) held = 1'b0;
            cycle();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; a = 8'hFF; b = 8'hFF;
        cycle();
        cycle();
        rst = 1'b0; start = 1'b0;
        checks++;
        if ({busy, done, sum, c_out} !== '0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b sum=%h c_out=%b, expected all zero",
                     busy, done, sum, c_out);
        end
    endtask

    task automatic test_zero();
        int lat, bc; logic [W-1:0] rs; logic rc; bit held;
        do_op(8'h00, 8'h00, 1'b0, lat, rs, rc, bc, held);
        checks++;
        if (lat !== int'(W)) begin
            errors++;
            $display("FAIL zero_latency: got %0d, expected %0d", lat, W);
        end
        checks++;
        if ({rc, rs} !== 9'h000) begin
            errors++;
            $display("FAIL zero_result: got %b_%h, expected 0_00", rc, rs);
        end
    endtask

    task automatic test_carry_out();
        int lat, bc; logic [W-1:0] rs; logic rc; bit held;
        do_op(8'hFF, 8'h01, 1'b0, lat, rs, rc, bc, held);
        checks++;
        if ({rc, rs} !== 9'h100) begin
            errors++;
            $display("FAIL ff_plus_01: got %b_%h, expected 1_00", rc, rs);
        end
        checks++;
        if (bc !== int'(W)) begin
            errors++;
            $display("FAIL busy_span: got %0d cycles, expected %0d", bc, W);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_with_done: got %b, expected 0", busy);
        end
        checks++;
        if (!held) begin
            errors++;
            $display("FAIL no_partial: sum/c_out changed before done, expected held");
        end
        cycle();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_single: got %b one cycle later, expected 0", done);
        end
    endtask

    task automatic test_patterns();
        int lat, bc; logic [W-1:0] rs; logic rc; bit held;
        do_op(8'hA5, 8'h5A, 1'b1, lat, rs, rc, bc, held);
        checks++;
        if ({rc, rs} !== 9'h100) begin
            errors++;
            $display("FAIL a5_5a_c1: got %b_%h, expected 1_00", rc, rs);
        end
        do_op(8'h7F, 8'h01, 1'b0, lat, rs, rc, bc, held);
        checks++;
        if ({rc, rs} !== 9'h080) begin
            errors++;
            $display("FAIL 7f_plus_01: got %b_%h, expected 0_80", rc, rs);
        end
        checks++;
        if (lat !== int'(W)) begin
            errors++;
            $display("FAIL pattern_latency: got %0d, expected %0d", lat, W);
        end
    endtask

    task automatic test_ignore_start();
        int ndone = 0;
        int first = -1;
        logic [W-1:0] rs = '0;
        logic rc = 1'b0;
        start = 1'b1; a = 8'h12; b = 8'h34; c_in = 1'b0;
        cycle();
        start = 1'b0;
        for (int i = 0; i <= int'(W) + 6; i++) begin
            if (i == 2) begin
                start = 1'b1; a = 8'hFF; b = 8'hFF; c_in = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                ndone++;
                if (first < 0) begin
                    first = i; rs = sum; rc = c_out;
                end
            end
            cycle();
        end
        checks++;
        if (ndone !== 1) begin
            errors++;
            $display("FAIL busy_start_dones: got %0d done pulses, expected 1", ndone);
        end
        checks++;
        if ({rc, rs} !== 9'h046 || first !== int'(W)) begin
            errors++;
            $display("FAIL busy_start_result: got %b_%h at %0d, expected 0_46 at %0d",
                     rc, rs, first, W);
        end
    endtask

    task automatic test_abort();
        int ndone = 0;
        int lat, bc; logic [W-1:0] rs; logic rc; bit held;
        start = 1'b1; a = 8'hFF; b = 8'hFF; c_in = 1'b0;
        cycle();
        start = 1'b0;
        cycle(); cycle(); cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        checks++;
        if ({busy, done, sum, c_out} !== '0) begin
            errors++;
            $display("FAIL abort_state: busy=%b done=%b sum=%h c_out=%b, expected all zero",
                     busy, done, sum, c_out);
        end
        for (int i = 0; i < int'(W) + 4; i++) begin
            if (done) ndone++;
            cycle();
        end
        checks++;
        if (ndone !== 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d done pulses, expected 0", ndone);
        end
        do_op(8'h03, 8'h04, 1'b0, lat, rs, rc, bc, held);
        checks++;
        if ({rc, rs} !== 9'h007 || lat !== int'(W)) begin
            errors++;
            $display("FAIL after_abort: got %b_%h lat %0d, expected 0_07 lat %0d",
                     rc, rs, lat, W);
        end
    endtask

    // With start held high, an idle adder accepts every PERIOD edges; each accepted
    // operand set must come back as a+b+c_in exactly W edges later.
    task automatic test_back_to_back();
        logic [W:0] expq[$];
        logic [W:0] exp;
        int nres = 0;
        bit want_done;
        for (int e = 0; e < 1000 * int'(PERIOD); e++) begin
            start = 1'b1;
            a = W'($urandom); b = W'($urandom); c_in = 1'($urandom);
            if (e % int'(PERIOD) == 0)
                expq.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, c_in});
            cycle();
            want_done = (e % int'(PERIOD) == int'(W));
            checks++;
            if (done !== want_done) begin
                errors++;
                $display("FAIL b2b_done_timing: edge %0d got %b, expected %b", e, done, want_done);
            end
            if (done && expq.size() > 0) begin
                exp = expq.pop_front();
                nres++;
                checks++;
                if ({c_out, sum} !== exp) begin
                    errors++;
                    $display("FAIL b2b_result: op %0d got %h, expected %h", nres, {c_out, sum}, exp);
                end
            end
        end
        start = 1'b0;
        checks++;
        if (nres !== 1000) begin
            errors++;
            $display("FAIL b2b_count: got %0d results, expected 1000", nres);
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_carry_out();
        test_patterns();
        test_ignore_start();
        test_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
